// File: rtl/cei_mochila_pkg.sv
// cei_mochila_pkg: shared types and helpers for the TMR recovery controller
package cei_mochila_pkg;
  localparam int unsigned TMR_NHARTS = 3;
  typedef enum logic [2:0] {
    TMR_MONITOR,
    TMR_CONFIRM,
    TMR_HALT,
    TMR_RESYNC,
    TMR_DONE,
    TMR_FATAL
  } tmr_rec_state_e;
  function automatic logic is_onehot(logic [TMR_NHARTS-1:0] v);
    return (v != '0) && ((v & (v - TMR_NHARTS'(1))) == '0);
  endfunction
endpackage

// File: rtl/tmr_recovery_ctrl.sv
// tmr_recovery_ctrl: filters voter mismatches and sequences halt/drain/resync recovery
module tmr_recovery_ctrl
  import cei_mochila_pkg::*;
#(
  parameter int unsigned NHARTS    = TMR_NHARTS,
  parameter int unsigned THRESHOLD = 4,
  parameter int unsigned CNT_W     = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              enable_i,
  input  logic              error_i,
  input  logic [NHARTS-1:0] error_id_i,
  input  logic              bus_idle_i,
  input  logic              resync_ack_i,
  output logic [NHARTS-1:0] halt_o,
  output logic              resync_req_o,
  output logic              voter_enable_o,
  output logic [NHARTS-1:0] faulty_id_o,
  output logic              irq_o,
  output logic              fatal_o,
  output logic [CNT_W-1:0]  fault_cnt_o,
  output logic [CNT_W-1:0]  transient_cnt_o
);
  if (NHARTS != 3 || THRESHOLD < 1 || THRESHOLD > 255) begin : g_param_check
    $fatal(1, "tmr_recovery_ctrl: NHARTS must be 3 and THRESHOLD within 1..255");
  end
  localparam logic [7:0] THR = 8'(THRESHOLD);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  tmr_rec_state_e state_q, state_d;
  logic [NHARTS-1:0] id_q, id_d, halt_q, halt_d;
  logic [7:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] fault_cnt_q, fault_cnt_d, transient_cnt_q, transient_cnt_d;
  logic resync_req_q, resync_req_d, voter_enable_q, voter_enable_d;
  logic irq_q, irq_d, fatal_q, fatal_d;
  logic single, multi;
  assign single = enable_i && error_i && is_onehot(error_id_i);
  assign multi  = enable_i && error_i && (error_id_i != '0) && !is_onehot(error_id_i);
  always_comb begin
    state_d         = state_q;
    id_d            = id_q;
    cnt_d           = cnt_q;
    fault_cnt_d     = fault_cnt_q;
    transient_cnt_d = transient_cnt_q;
    case (state_q)
      TMR_MONITOR:
        if (multi) begin
          state_d = TMR_FATAL;
          id_d    = error_id_i;
        end else if (single) begin
          id_d    = error_id_i;
          cnt_d   = 8'd1;
          state_d = (THR == 8'd1) ? TMR_HALT : TMR_CONFIRM;
        end
      TMR_CONFIRM:
        if (multi) begin
          state_d = TMR_FATAL;
          id_d    = error_id_i;
        end else if (single && error_id_i == id_q) begin
          cnt_d   = cnt_q + 8'd1;
          state_d = (cnt_d == THR) ? TMR_HALT : TMR_CONFIRM;
        end else begin
          transient_cnt_d = (transient_cnt_q == CNT_MAX) ? transient_cnt_q : transient_cnt_q + CNT_W'(1);
          id_d            = '0;
          cnt_d           = '0;
          state_d         = TMR_MONITOR;
        end
      TMR_HALT:
        state_d = bus_idle_i ? TMR_RESYNC : TMR_HALT;
      TMR_RESYNC:
        if (resync_ack_i) begin
          fault_cnt_d = (fault_cnt_q == CNT_MAX) ? fault_cnt_q : fault_cnt_q + CNT_W'(1);
          id_d        = '0;
          state_d     = TMR_DONE;
        end
      TMR_DONE:
        state_d = TMR_MONITOR;
      default: ;
    endcase
    halt_d         = (state_d inside {TMR_HALT, TMR_RESYNC, TMR_FATAL}) ? '1 : '0;
    resync_req_d   = state_d == TMR_RESYNC;
    voter_enable_d = enable_i && !(state_d inside {TMR_RESYNC, TMR_FATAL});
    irq_d          = state_d == TMR_DONE;
    fatal_d        = state_d == TMR_FATAL;
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q         <= TMR_MONITOR;
      id_q            <= '0;
      cnt_q           <= '0;
      fault_cnt_q     <= '0;
      transient_cnt_q <= '0;
      halt_q          <= '0;
      resync_req_q    <= 1'b0;
      voter_enable_q  <= 1'b0;
      irq_q           <= 1'b0;
      fatal_q         <= 1'b0;
    end else begin
      state_q         <= state_d;
      id_q            <= id_d;
      cnt_q           <= cnt_d;
      fault_cnt_q     <= fault_cnt_d;
      transient_cnt_q <= transient_cnt_d;
      halt_q          <= halt_d;
      resync_req_q    <= resync_req_d;
      voter_enable_q  <= voter_enable_d;
      irq_q           <= irq_d;
      fatal_q         <= fatal_d;
    end
  end
  assign halt_o          = halt_q;
  assign resync_req_o    = resync_req_q;
  assign voter_enable_o  = voter_enable_q;
  assign faulty_id_o     = id_q;
  assign irq_o           = irq_q;
  assign fatal_o         = fatal_q;
  assign fault_cnt_o     = fault_cnt_q;
  assign transient_cnt_o = transient_cnt_q;
endmodule

// File: tb/tb_tmr_recovery_ctrl.sv
// tb_tmr_recovery_ctrl: directed and randomized checks against a behavioural recovery model
module tb_tmr_recovery_ctrl;
  localparam int TH = 4;
  localparam int CW = 2;
  localparam int CMAX = (1 << CW) - 1;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0, err = 1'b0, idle = 1'b0, ack = 1'b0;
  logic [2:0] eid = '0;
  logic [2:0] halt, fid;
  logic req, ven, irq, fatal;
  logic [CW-1:0] fcnt, tcnt;
  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;
  bit m_fatal, m_halt, m_resync, m_done, m_ven;
  int run, m_tc, m_fc;
  logic [2:0] m_id;
  tmr_recovery_ctrl #(.NHARTS(3), .THRESHOLD(TH), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(en), .error_i(err), .error_id_i(eid),
    .bus_idle_i(idle), .resync_ack_i(ack), .halt_o(halt), .resync_req_o(req),
    .voter_enable_o(ven), .faulty_id_o(fid), .irq_o(irq), .fatal_o(fatal),
    .fault_cnt_o(fcnt), .transient_cnt_o(tcnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask
  function automatic int sat(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction
  task automatic model_update();
    int pc;
    bit sgl, mul;
    pc  = $countones(eid);
    sgl = en && err && pc == 1;
    mul = en && err && pc >= 2;
    if (!rst_n) begin
      m_fatal = 0; m_halt = 0; m_resync = 0; m_done = 0; m_ven = 0;
      run = 0; m_id = '0; m_tc = 0; m_fc = 0;
      return;
    end
    if (m_fatal) begin
    end else if (m_done) m_done = 0;
    else if (m_resync) begin
      if (ack) begin m_resync = 0; m_done = 1; m_id = '0; m_fc = sat(m_fc); end
    end else if (m_halt) begin
      if (idle) begin m_halt = 0; m_resync = 1; end
    end else if (mul) begin
      m_fatal = 1; m_id = eid; run = 0;
    end else if (run > 0 && !(sgl && eid == m_id)) begin
      m_tc = sat(m_tc); run = 0; m_id = '0;
    end else if (sgl) begin
      run++;
      m_id = eid;
      if (run == TH) begin m_halt = 1; run = 0; end
    end
    m_ven = en && !m_resync && !m_fatal;
  endtask
  task automatic step(input logic e, input logic er, input logic [2:0] id, input logic bi, input logic ak);
    en = e; err = er; eid = id; idle = bi; ack = ak;
    @(posedge clk);
    model_update();
    #1;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    step(1, 0, 3'b000, 0, 0);
    step(1, 0, 3'b000, 0, 0);
    rst_n = 1'b1;
  endtask
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("halt_o", int'(halt), (m_halt || m_resync || m_fatal) ? 7 : 0);
      chk("resync_req_o", int'(req), int'(m_resync));
      chk("voter_enable_o", int'(ven), int'(m_ven));
      chk("faulty_id_o", int'(fid), int'(m_id));
      chk("irq_o", int'(irq), int'(m_done));
      chk("fatal_o", int'(fatal), int'(m_fatal));
      chk("fault_cnt_o", int'(fcnt), m_fc);
      chk("transient_cnt_o", int'(tcnt), m_tc);
    end
  end
  initial begin
    logic [2:0] fav;
    int r;
    do_reset();
    chk_en = 1'b1;
    chk("reset halt", int'(halt), 0);
    chk("reset voter_enable", int'(ven), 0);
    chk("reset counts", int'(fcnt) + int'(tcnt), 0);
    // transient glitch on hart 1
    step(1, 1, 3'b010, 0, 0);
    step(1, 1, 3'b010, 0, 0);
    step(1, 0, 3'b000, 0, 0);
    chk("glitch transient_cnt", int'(tcnt), 1);
    chk("glitch halt", int'(halt), 0);
    chk("glitch faulty_id", int'(fid), 0);
    // persistent fault on hart 2
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 1, 3'b100, 1, 0);
    chk("persist halt before t+4", int'(halt), 0);
    step(1, 1, 3'b100, 1, 0);
    chk("persist halt at t+4", int'(halt), 7);
    chk("persist faulty_id", int'(fid), 4);
    step(1, 0, 3'b000, 1, 0);
    chk("persist resync_req", int'(req), 1);
    for (int i = 0; i < 3; i++) step(1, 0, 3'b000, 1, 0);
    chk("persist req held", int'(req), 1);
    step(1, 0, 3'b000, 1, 1);
    chk("done irq", int'(irq), 1);
    chk("done halt", int'(halt), 0);
    chk("done faulty_id", int'(fid), 0);
    chk("done fault_cnt", int'(fcnt), 1);
    step(1, 0, 3'b000, 1, 0);
    chk("irq one cycle", int'(irq), 0);
    // multi fault from MONITOR
    do_reset();
    step(1, 1, 3'b011, 0, 0);
    chk("multi fatal", int'(fatal), 1);
    chk("multi halt", int'(halt), 7);
    chk("multi faulty_id", int'(fid), 3);
    for (int i = 0; i < 5; i++) step(1, 0, 3'b000, 1, 1);
    chk("fatal sticky", int'(fatal), 1);
    do_reset();
    chk("fatal cleared by reset", int'(fatal), 0);
    // multi fault in third CONFIRM cycle
    for (int i = 0; i < 3; i++) step(1, 1, 3'b010, 0, 0);
    step(1, 1, 3'b011, 0, 0);
    chk("confirm multi fatal", int'(fatal), 1);
    chk("confirm multi faulty_id", int'(fid), 3);
    // id switch
    do_reset();
    step(1, 1, 3'b001, 0, 0);
    step(1, 1, 3'b001, 0, 0);
    step(1, 1, 3'b100, 0, 0);
    chk("switch transient_cnt", int'(tcnt), 1);
    chk("switch back to monitor", int'(fid), 0);
    step(1, 1, 3'b100, 0, 0);
    chk("switch fresh confirm", int'(fid), 4);
    // bus not idle in HALT, then reset mid-RESYNC
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 1, 3'b001, 0, 0);
    for (int i = 0; i < 10; i++) begin
      step(1, 1, 3'b011, 0, 0);
      chk("halt no req", int'(req), 0);
      chk("halt ignores errors", int'(fatal), 0);
    end
    step(1, 0, 3'b000, 1, 0);
    step(1, 0, 3'b000, 1, 0);
    chk("resync entered", int'(req), 1);
    rst_n = 1'b0;
    step(1, 0, 3'b000, 1, 0);
    chk("mid-resync reset halt", int'(halt), 0);
    chk("mid-resync reset req", int'(req), 0);
    chk("mid-resync reset ven", int'(ven), 0);
    chk("mid-resync reset faulty_id", int'(fid), 0);
    rst_n = 1'b1;
    // transient saturation and disabled mode
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1, 1, 3'b010, 0, 0);
      step(1, 0, 3'b000, 0, 0);
    end
    chk("transient saturates", int'(tcnt), 3);
    for (int i = 0; i < 3; i++) step(0, 1, 3'b011, 0, 0);
    chk("disabled no fatal", int'(fatal), 0);
    chk("disabled no id", int'(fid), 0);
    chk("disabled voter off", int'(ven), 0);
    // randomized traffic
    do_reset();
    fav = 3'b001;
    for (int i = 0; i < 4000; i++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 29) == 0) fav = 3'(1 << $urandom_range(0, 2));
      r = $urandom_range(0, 99);
      step($urandom_range(0, 19) != 0, $urandom_range(0, 9) != 0,
           r < 60 ? fav : r < 70 ? 3'(1 << $urandom_range(0, 2)) : r < 76 ? 3'($urandom_range(0, 7)) : 3'b000,
           $urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0);
    end
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/tmr_recovery_ctrl.md
# tmr_recovery_ctrl

Sequential fault manager that sits directly downstream of the TMR bus voter. It consumes the voter's per-cycle mismatch flags and filters transient glitches from persistent faults. On a persistent single-hart fault it halts all harts, drains the voted bus, runs a resynchronisation handshake and reports the fault. Disagreement among two or more harts, where voting is no longer meaningful, drives it into a sticky fatal state.

## Interface
- NHARTS, 3: number of redundant harts; only 3 is supported.
- THRESHOLD, 4: consecutive mismatch cycles, all on the same hart, that confirm a fault; range 1..255.
- CNT_W, 8: width of the saturating event counters.

- clk_i  in  1  clock.
- rst_ni  in  1  reset; synchronous, active-low.
- enable_i  in  1  TMR mode active; low forces MONITOR behaviour and blocks new detection.
- error_i  in  1  voter aggregate mismatch flag.
- error_id_i  in  NHARTS  voter per-hart mismatch flags.
- bus_idle_i  in  1  no outstanding transactions on the voted instr and data buses.
- resync_ack_i  in  1  resync routine finished; level, sampled only in RESYNC.
- halt_o  out  NHARTS  halt request to every hart.
- resync_req_o  out  1  resync request.
- voter_enable_o  out  1  enable for the voter checker.
- faulty_id_o  out  NHARTS  one-hot id of the hart under confirmation or recovery; zero otherwise.
- irq_o  out  1  one-cycle pulse on recovery completion.
- fatal_o  out  1  sticky multi-hart fault flag.
- fault_cnt_o  out  CNT_W  confirmed faults recovered, saturating.
- transient_cnt_o  out  CNT_W  mismatches discarded as transient, saturating.

## Operation
- All outputs are Moore outputs, decoded from registers only.
- The FSM has six states: MONITOR, CONFIRM, HALT, RESYNC, DONE and FATAL.
- A mismatch is valid only when enable_i=1 and error_i=1. Single means error_id_i is one-hot; multi means popcount(error_id_i)≥2. error_i=1 with error_id_i=0 is treated as no mismatch.
- MONITOR
  - Single mismatch: latch the id and set cnt=1. Go to CONFIRM, or straight to HALT if THRESHOLD=1.
  - Multi mismatch: go to FATAL.
- CONFIRM
  - Same single id: cnt+1; when cnt reaches THRESHOLD, go to HALT.
  - No mismatch, a different single id, or enable_i=0: transient_cnt+1, clear the id, go to MONITOR.
  - Multi mismatch: go to FATAL. Multi takes priority over every other condition.
- HALT
  - halt_o all ones.
  - Wait for bus_idle_i=1, then go to RESYNC.
  - error_i is ignored.
- RESYNC
  - halt_o all ones, resync_req_o=1, voter_enable_o=0.
  - On resync_ack_i=1: fault_cnt+1, go to DONE.
- DONE
  - One cycle; irq_o=1, halt_o=0, faulty_id_o cleared.
  - Then go to MONITOR.
- FATAL
  - fatal_o=1, halt_o all ones, voter_enable_o=0.
  - Left only by reset.
- voter_enable_o equals enable_i in MONITOR, CONFIRM, HALT and DONE.
- faulty_id_o holds the latched id in CONFIRM, HALT and RESYNC. In FATAL it holds error_id_i as captured on entry.
- Both counters saturate at 2^CNT_W−1 and never wrap.
- The confirmation counter cnt is 8 bits and only ever compared for equality with THRESHOLD.

## Timing
- Reset values, effective at the first rising edge with rst_ni=0:
  - state = MONITOR
  - halt_o = 0, resync_req_o = 0, irq_o = 0, fatal_o = 0
  - faulty_id_o = 0, fault_cnt_o = 0, transient_cnt_o = 0
  - voter_enable_o = 0 during reset, then follows enable_i
- Reset in any state, including FATAL and RESYNC mid-handshake, aborts the operation immediately.
- Detection latency: when the first mismatch is in cycle t, the state is CONFIRM in t+1. If mismatches persist through t+THRESHOLD−1, halt_o rises in cycle t+THRESHOLD.
- HALT→RESYNC: one cycle after bus_idle_i is first seen high in HALT. If bus_idle_i is already high, the minimum HALT dwell is one cycle.
- RESYNC→DONE: one cycle after resync_ack_i is sampled high. irq_o is high for exactly the following cycle.
- An ack that is already high on RESYNC entry is accepted in the first RESYNC cycle.
- resync_req_o stays high until the DONE cycle.
- Counter updates become visible in the cycle after the triggering transition.

## Structure
- The shared package cei_mochila_pkg gains:
  - the enum tmr_rec_state_e, 3 bits, with the six states above;
  - the localparam TMR_NHARTS=3;
  - the function is_onehot(logic [NHARTS-1:0]), also used for the multi check.
- This is a single module with no sub-module.
- The counters are inline saturating registers.
- An elaboration-time assertion enforces NHARTS==3 and 1≤THRESHOLD≤255.

## Test plan
- Transient glitch: error_id_i=3'b010 for 2 cycles with THRESHOLD=4 → no halt_o, transient_cnt_o=1, state back to MONITOR.
- Persistent fault on hart 2, bus_idle_i=1, ack 3 cycles after resync_req_o → halt_o=3'b111 exactly 4 cycles after the first error; faulty_id_o=3'b100; irq_o pulses once; fault_cnt_o=1; halt_o=0 in the DONE cycle.
- Multi fault: error_id_i=3'b011 in MONITOR, and separately in the third CONFIRM cycle → fatal_o=1 sticky, halt_o=3'b111, faulty_id_o=3'b011. Only reset clears it.
- Id switch: 3'b001 for 2 cycles, then 3'b100 → transient_cnt_o=1, return to MONITOR, then a fresh confirmation of 3'b100 starts on the next cycle.
- Bus not idle: hold bus_idle_i=0 for 10 cycles in HALT → resync_req_o stays 0 and errors are ignored. Reset asserted mid-RESYNC → all outputs return to their reset values.
- Saturation with CNT_W=2: drive 5 transients → transient_cnt_o=3. enable_i=0 with errors present → no state change.
